mem_port_arb: RTL
=================

MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 Parameter MEM_BYTES, default 8192: size in bytes of the shared byte-addressed memory behind the port.
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 if_req_valid  in  1 / if_req_addr  in  32 / if_req_ready  out  1: instruction-fetch requester, 32-bit word reads only.
REQ-005 if_flush  in  1: kills all in-flight IF reads.
REQ-006 if_rsp_valid  out  1 / if_rsp_data  out  32 / if_rsp_err  out  1: IF read response.
REQ-007 ls_req_valid  in  1 / ls_req_we  in  1 / ls_req_addr  in  32 / ls_req_wdata  in  32 / ls_req_wsz  in  3 / ls_req_ready  out  1: load/store requester; wsz uses the ACCESS_SZ_* encodings from defs.v.
REQ-008 ls_rsp_valid  out  1 / ls_rsp_data  out  32 / ls_rsp_err  out  1: LS read response and write acknowledge.
REQ-009 mem_re  out  1 / mem_raddr  out  32 / mem_we  out  1 / mem_waddr  out  32 / mem_wdata  out  32 / mem_wsz  out  3: memory port commands.
REQ-010 mem_rdata  in  32 / mem_hit  in  1: memory read return, valid exactly 2 cycles after the mem_re cycle.

Function
REQ-011 At most one request is accepted per cycle; a request is accepted when valid and ready are both high in the same cycle.
REQ-012 Ready is combinational from the valids and the priority register: grant to the sole valid requester; on contention, grant to the requester not granted last (round-robin).
REQ-013 The priority register updates only on acceptance under contention; no contention leaves it unchanged.
REQ-014 Accepted read (IF, or LS with we=0): mem_re=1 and mem_raddr=addr in the same cycle (combinational pass-through); mem_we=0.
REQ-015 Accepted LS write: mem_we=1, mem_waddr/wdata/wsz driven from the request in the same cycle; mem_re=0.
REQ-016 With no acceptance in a cycle, mem_re=0 and mem_we=0.
REQ-017 Write range check: addr + size > MEM_BYTES (size 1/2/4 for byte/half/other) forces mem_we=0; the write is still accepted and flagged as an error.
REQ-018 A 2-stage tag pipeline (valid, owner IF/LS, type read/write, err) tracks every accepted request; up to 2 requests are outstanding; acceptance never stalls on outstanding count.
REQ-019 Read response: in cycle N+2 after acceptance in cycle N, the owner's rsp_valid=1, rsp_data=mem_rdata, rsp_err=~mem_hit.
REQ-020 Write acknowledge: ls_rsp_valid=1 in cycle N+2, ls_rsp_data=0, ls_rsp_err=range-error flag; acknowledges share the read timing so LS responses stay in order.
REQ-021 Responses have no backpressure; at most one of if_rsp_valid/ls_rsp_valid is high per cycle.
REQ-022 if_flush=1 invalidates every IF-owned tag in both stages in that cycle; an IF request accepted in the flush cycle is not invalidated.
REQ-023 LS tags are never affected by if_flush.
REQ-024 rsp_data and rsp_err are 0 whenever the corresponding rsp_valid is 0.
REQ-025 A read accepted in the cycle after a write to the same address returns the newly written data (memory forwards); the arbiter inserts no stall.

Reset
REQ-026 When rst_n=0 at posedge clk: tag pipeline cleared, priority set to IF, all rsp_valid/rsp_err=0, rsp_data=0.
REQ-027 While rst_n=0, if_req_ready, ls_req_ready, mem_re and mem_we are 0 regardless of inputs.
REQ-028 Reset asserted with requests in flight drops them; no response is produced for them after reset deasserts.

Verification
REQ-029 IF read 0x100 alone, memory word 0x11223344 -> mem_re in cycle N, if_rsp_valid=1 with data 0x11223344, err=0 in N+2.
REQ-030 IF and LS valid together for 4 cycles from reset -> grants IF, LS, IF, LS; responses return in the same order, 2 cycles after each grant.
REQ-031 LS word write 0x1FFE (MEM_BYTES=8192) -> mem_we stays 0, ls_rsp_valid=1 with ls_rsp_err=1 two cycles later.
REQ-032 Two back-to-back IF reads, if_flush in the cycle after the second acceptance -> no if_rsp_valid for either read.
REQ-033 LS word write 0xCAFEF00D to 0x40, then LS read 0x40 in the next cycle -> write ack, then read response data 0xCAFEF00D.
REQ-034 rst_n low for 1 cycle with 2 reads in flight -> no responses after reset; the first contended grant goes to IF.

Source files
------------

// File: rtl/mem_port_arb.sv
// mem_port_arb: round-robin IF/LS arbiter for one memory port with 2-stage tag pipeline; ports: IF req/flush/rsp, LS req/rsp, mem cmd/return, clk, rst_n (sync, active-low)
module mem_port_arb #(
   parameter int MEM_BYTES = 8192
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req_valid,
   input  logic [31:0] if_req_addr,
   output logic        if_req_ready,
   input  logic        if_flush,
   output logic        if_rsp_valid,
   output logic [31:0] if_rsp_data,
   output logic        if_rsp_err,
   input  logic        ls_req_valid,
   input  logic        ls_req_we,
   input  logic [31:0] ls_req_addr,
   input  logic [31:0] ls_req_wdata,
   input  logic [2:0]  ls_req_wsz,
   output logic        ls_req_ready,
   output logic        ls_rsp_valid,
   output logic [31:0] ls_rsp_data,
   output logic        ls_rsp_err,
   output logic        mem_re,
   output logic [31:0] mem_raddr,
   output logic        mem_we,
   output logic [31:0] mem_waddr,
   output logic [31:0] mem_wdata,
   output logic [2:0]  mem_wsz,
   input  logic [31:0] mem_rdata,
   input  logic        mem_hit
);
   localparam logic [2:0] ACCESS_SZ_BYTE = 3'd0;
   localparam logic [2:0] ACCESS_SZ_HALF = 3'd1;
   logic        prio_ls;
   logic        s1_v, s1_ls, s1_wr, s1_err;
   logic        s2_v, s2_ls, s2_wr, s2_err;
   logic        s2_live;
   logic [2:0]  nbytes;
   logic [32:0] end_addr;
   logic        range_err;
   assign if_req_ready = rst_n & if_req_valid & (~ls_req_valid | ~prio_ls);
   assign ls_req_ready = rst_n & ls_req_valid & (~if_req_valid | prio_ls);
   assign nbytes    = (ls_req_wsz == ACCESS_SZ_BYTE) ? 3'd1 : (ls_req_wsz == ACCESS_SZ_HALF) ? 3'd2 : 3'd4;
   assign end_addr  = {1'b0, ls_req_addr} + {30'd0, nbytes};
   assign range_err = end_addr > 33'(MEM_BYTES);
   assign mem_re    = if_req_ready | (ls_req_ready & ~ls_req_we);
   assign mem_raddr = if_req_ready ? if_req_addr : ls_req_addr;
   assign mem_we    = ls_req_ready & ls_req_we & ~range_err;
   assign mem_waddr = ls_req_addr;
   assign mem_wdata = ls_req_wdata;
   assign mem_wsz   = ls_req_wsz;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prio_ls <= 1'b0;
         s1_v    <= 1'b0;
         s1_ls   <= 1'b0;
         s1_wr   <= 1'b0;
         s1_err  <= 1'b0;
         s2_v    <= 1'b0;
         s2_ls   <= 1'b0;
         s2_wr   <= 1'b0;
         s2_err  <= 1'b0;
      end else begin
         if (if_req_valid && ls_req_valid) prio_ls <= if_req_ready;
         s1_v   <= if_req_ready | ls_req_ready;
         s1_ls  <= ls_req_ready;
         s1_wr  <= ls_req_ready & ls_req_we;
         s1_err <= ls_req_ready & ls_req_we & range_err;
         s2_v   <= s1_v & ~(if_flush & ~s1_ls);
         s2_ls  <= s1_ls;
         s2_wr  <= s1_wr;
         s2_err <= s1_err;
      end
   end
   // flush also kills the IF response surfacing in the flush cycle itself
   assign s2_live      = rst_n & s2_v & ~(if_flush & ~s2_ls);
   assign if_rsp_valid = s2_live & ~s2_ls;
   assign if_rsp_data  = if_rsp_valid ? mem_rdata : 32'd0;
   assign if_rsp_err   = if_rsp_valid & ~mem_hit;
   assign ls_rsp_valid = s2_live & s2_ls;
   assign ls_rsp_data  = (ls_rsp_valid & ~s2_wr) ? mem_rdata : 32'd0;
   assign ls_rsp_err   = ls_rsp_valid & (s2_wr ? s2_err : ~mem_hit);
endmodule
